// File: rtl/instruction_decoder_pkg.sv
// -----------------------------------------------------------------------------
// instruction_decoder_pkg
// Shared definitions for the instruction decoder slice: instruction field bit
// positions, FUNTYPE codes, memory-class FUNCODE codes and register-file
// geometry. Imported by register_file and instruction_decoder.
// -----------------------------------------------------------------------------
package instruction_decoder_pkg;

  // Register-file geometry
  localparam int REG_COUNT = 16;
  localparam int IDX_W     = 4;
  localparam int INSTR_W   = 32;

  // Instruction field positions
  localparam int FUNTYPE_HI = 31;
  localparam int FUNTYPE_LO = 30;
  localparam int FUNCODE_HI = 29;
  localparam int FUNCODE_LO = 28;
  localparam int RD_HI      = 27;
  localparam int RD_LO      = 24;
  localparam int RN_HI      = 23;
  localparam int RN_LO      = 20;
  localparam int RM_HI      = 19;
  localparam int RM_LO      = 16;
  localparam int IMM16_HI   = 15;
  localparam int IMM16_LO   = 0;
  localparam int IMM24_HI   = 23;
  localparam int IMM24_LO   = 0;

  // Instruction class
  typedef enum logic [1:0] {
    FT_ALU_REG = 2'b00,
    FT_ALU_IMM = 2'b01,
    FT_MEM     = 2'b10,
    FT_BRANCH  = 2'b11
  } funtype_e;

  // Operation within the memory/cache class
  typedef enum logic [1:0] {
    FC_MEM_RD   = 2'b00,
    FC_MEM_WR   = 2'b01,
    FC_CACHE_WR = 2'b10,
    FC_CACHE_SH = 2'b11
  } mem_funcode_e;

endpackage

// File: rtl/instruction_decoder_register_file.sv
// -----------------------------------------------------------------------------
// register_file
// 16 x N general-purpose registers, three combinational read ports and one
// synchronous write port. A read whose index matches the write index while
// we=1 returns wr_data in the same cycle (write-through bypass), including
// while rst is asserted.
//
// Ports
//   clk                    rising-edge clock
//   rst                    synchronous active-high reset, clears all registers
//   we, wr_idx, wr_data    write port
//   rd_idx_a/b/c           read indices
//   rd_data_a/b/c          read data (bypassed)
// -----------------------------------------------------------------------------
module register_file
  import instruction_decoder_pkg::*;
#(
  parameter int N = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [N-1:0]     wr_data,
  input  logic [IDX_W-1:0] rd_idx_a,
  input  logic [IDX_W-1:0] rd_idx_b,
  input  logic [IDX_W-1:0] rd_idx_c,
  output logic [N-1:0]     rd_data_a,
  output logic [N-1:0]     rd_data_b,
  output logic [N-1:0]     rd_data_c
);

  logic [N-1:0] regs [REG_COUNT];

  // NOTE: clearing a memory array on reset forces it into flops instead of a
  // RAM macro; here it is intentional because every register must read 0
  // after reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[wr_idx] <= wr_data;
    end
  end

  // Bypass stays live during reset: only the array update is suppressed.
  assign rd_data_a = (we && (rd_idx_a == wr_idx)) ? wr_data : regs[rd_idx_a];
  assign rd_data_b = (we && (rd_idx_b == wr_idx)) ? wr_data : regs[rd_idx_b];
  assign rd_data_c = (we && (rd_idx_c == wr_idx)) ? wr_data : regs[rd_idx_c];

endmodule

// File: rtl/instruction_decoder.sv
// -----------------------------------------------------------------------------
// instruction_decoder
// Zero-latency decode stage: splits the instruction word into fields, reads
// the register file (RN, RM, RD) and produces ALU/address operands, store
// data and control strobes.
//
// Ports
//   clk, rst                     clock and synchronous active-high reset
//   instruction                  32-bit instruction word
//   WBd, RDwb, WE                register write-back (data, index, enable)
//   PCi                          PC of the current instruction
//   OPA, OPB                     operands
//   STR_DATA                     R[RD] (store / compare data)
//   PCo                          PCi passed through
//   RKo                          R[RM] unconditionally
//   RDo, FUNTYPE, FUNCODE        raw instruction fields
//   selWB .. selBRANCH           control strobes
// -----------------------------------------------------------------------------
module instruction_decoder
  import instruction_decoder_pkg::*;
#(
  parameter int N = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instruction,
  input  logic [N-1:0]       WBd,
  input  logic [N-1:0]       PCi,
  input  logic [IDX_W-1:0]   RDwb,
  input  logic               WE,
  output logic [N-1:0]       OPA,
  output logic [N-1:0]       OPB,
  output logic [N-1:0]       STR_DATA,
  output logic [N-1:0]       PCo,
  output logic [N-1:0]       RKo,
  output logic [IDX_W-1:0]   RDo,
  output logic [1:0]         FUNTYPE,
  output logic [1:0]         FUNCODE,
  output logic               selWB,
  output logic               selMEMRD,
  output logic               selMEMWR,
  output logic               selCACHEWR,
  output logic               selCACHESH,
  output logic               selBRANCH
);

  logic [IDX_W-1:0] rn_idx;
  logic [IDX_W-1:0] rm_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [15:0]      imm16;
  logic [23:0]      imm24;
  logic [N-1:0]     imm16_sext;
  logic [N-1:0]     imm24_sext;
  logic [N-1:0]     rn_data;
  logic [N-1:0]     rm_data;
  logic [N-1:0]     rd_data;
  funtype_e         ftype;
  mem_funcode_e     mcode;

  assign rd_idx = instruction[RD_HI:RD_LO];
  assign rn_idx = instruction[RN_HI:RN_LO];
  assign rm_idx = instruction[RM_HI:RM_LO];
  assign imm16  = instruction[IMM16_HI:IMM16_LO];
  assign imm24  = instruction[IMM24_HI:IMM24_LO];
  assign ftype  = funtype_e'(instruction[FUNTYPE_HI:FUNTYPE_LO]);
  assign mcode  = mem_funcode_e'(instruction[FUNCODE_HI:FUNCODE_LO]);

  assign imm16_sext = {{(N-16){imm16[15]}}, imm16};
  assign imm24_sext = {{(N-24){imm24[23]}}, imm24};

  register_file #(.N(N)) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .we        (WE),
    .wr_idx    (RDwb),
    .wr_data   (WBd),
    .rd_idx_a  (rn_idx),
    .rd_idx_b  (rm_idx),
    .rd_idx_c  (rd_idx),
    .rd_data_a (rn_data),
    .rd_data_b (rm_data),
    .rd_data_c (rd_data)
  );

  assign STR_DATA = rd_data;
  assign RKo      = rm_data;
  assign PCo      = PCi;
  assign RDo      = rd_idx;
  assign FUNTYPE  = instruction[FUNTYPE_HI:FUNTYPE_LO];
  assign FUNCODE  = instruction[FUNCODE_HI:FUNCODE_LO];

  // NOTE: every output of this block gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    OPA        = rn_data;
    OPB        = imm16_sext;
    selWB      = 1'b0;
    selMEMRD   = 1'b0;
    selMEMWR   = 1'b0;
    selCACHEWR = 1'b0;
    selCACHESH = 1'b0;
    selBRANCH  = 1'b0;
    unique case (ftype)
      FT_ALU_REG: begin
        OPB   = rm_data;
        selWB = 1'b1;
      end
      FT_ALU_IMM: begin
        selWB = 1'b1;
      end
      FT_MEM: begin
        unique case (mcode)
          FC_MEM_RD: begin
            // Loads write the fetched word back, hence selWB alongside.
            selWB    = 1'b1;
            selMEMRD = 1'b1;
          end
          FC_MEM_WR:   selMEMWR   = 1'b1;
          FC_CACHE_WR: selCACHEWR = 1'b1;
          FC_CACHE_SH: selCACHESH = 1'b1;
        endcase
      end
      FT_BRANCH: begin
        OPA       = PCi;
        OPB       = imm24_sext;
        selBRANCH = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_instruction_decoder.sv
// -----------------------------------------------------------------------------
// tb_instruction_decoder
// Directed bench for instruction_decoder. Each step drives inputs, pushes the
// expected output set onto a scoreboard queue and then pops and compares it
// against the DUT on the following falling edge.
// -----------------------------------------------------------------------------
module tb_instruction_decoder;

  localparam int N = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   instruction;
  logic [N-1:0]  WBd;
  logic [N-1:0]  PCi;
  logic [3:0]    RDwb;
  logic          WE;
  logic [N-1:0]  OPA, OPB, STR_DATA, PCo, RKo;
  logic [3:0]    RDo;
  logic [1:0]    FUNTYPE, FUNCODE;
  logic          selWB, selMEMRD, selMEMWR, selCACHEWR, selCACHESH, selBRANCH;

  always #5 clk = ~clk;

  instruction_decoder #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .WBd         (WBd),
    .PCi         (PCi),
    .RDwb        (RDwb),
    .WE          (WE),
    .OPA         (OPA),
    .OPB         (OPB),
    .STR_DATA    (STR_DATA),
    .PCo         (PCo),
    .RKo         (RKo),
    .RDo         (RDo),
    .FUNTYPE     (FUNTYPE),
    .FUNCODE     (FUNCODE),
    .selWB       (selWB),
    .selMEMRD    (selMEMRD),
    .selMEMWR    (selMEMWR),
    .selCACHEWR  (selCACHEWR),
    .selCACHESH  (selCACHESH),
    .selBRANCH   (selBRANCH)
  );

  // Strobe vector order: {selWB, selMEMRD, selMEMWR, selCACHEWR, selCACHESH, selBRANCH}
  typedef struct packed {
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] str;
    logic [31:0] pco;
    logic [31:0] rko;
    logic [3:0]  rdo;
    logic [1:0]  ft;
    logic [1:0]  fc;
    logic [5:0]  sel;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] opa, input logic [31:0] opb,
                              input logic [31:0] str, input logic [31:0] pco,
                              input logic [31:0] rko, input logic [3:0] rdo,
                              input logic [1:0] ft, input logic [1:0] fc,
                              input logic [5:0] sel);
    exp_t e;
    e.opa = opa; e.opb = opb; e.str = str; e.pco = pco; e.rko = rko;
    e.rdo = rdo; e.ft = ft; e.fc = fc; e.sel = sel;
    return e;
  endfunction

  // Reference strobe table, written as a flat lookup on {FUNTYPE, FUNCODE}.
  function automatic logic [5:0] strobe_ref(input logic [1:0] ft, input logic [1:0] fc);
    logic [3:0] code;
    code = {ft, fc};
    casez (code)
      4'b00??: return 6'b100000;
      4'b01??: return 6'b100000;
      4'b1000: return 6'b110000;
      4'b1001: return 6'b001000;
      4'b1010: return 6'b000100;
      4'b1011: return 6'b000010;
      default: return 6'b000001;
    endcase
  endfunction

  task automatic expect_out(input exp_t e);
    sb.push_back(e);
  endtask

  // Sample on the falling edge, away from the register write edge.
  task automatic compare_out(input string tag);
    exp_t e;
    @(negedge clk);
    checks++;
    assert (sb.size() != 0) else begin
      failures++;
      $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, ".OPA"},      OPA,      e.opa);
      check({tag, ".OPB"},      OPB,      e.opb);
      check({tag, ".STR_DATA"}, STR_DATA, e.str);
      check({tag, ".PCo"},      PCo,      e.pco);
      check({tag, ".RKo"},      RKo,      e.rko);
      check({tag, ".RDo"},      {28'd0, RDo},     {28'd0, e.rdo});
      check({tag, ".FUNTYPE"},  {30'd0, FUNTYPE}, {30'd0, e.ft});
      check({tag, ".FUNCODE"},  {30'd0, FUNCODE}, {30'd0, e.fc});
      check({tag, ".sel"},
            {26'd0, selWB, selMEMRD, selMEMWR, selCACHEWR, selCACHESH, selBRANCH},
            {26'd0, e.sel});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [3:0] idx, input logic [31:0] val);
    WE = 1'b1; RDwb = idx; WBd = val;
    tick();
    WE = 1'b0;
  endtask

  initial begin
    logic [31:0] instr;
    logic [31:0] opa_e, opb_e;

    rst = 1'b1; WE = 1'b0; RDwb = '0; WBd = '0; PCi = '0; instruction = '0;
    tick();
    rst = 1'b0;

    // Post-reset state with instruction 0
    expect_out(mk(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 4'd0, 2'd0, 2'd0, 6'b100000));
    compare_out("reset_instr0");

    // ALU-register after reset
    instruction = 32'h21130000;
    expect_out(mk(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 4'd1, 2'b00, 2'b10, 6'b100000));
    compare_out("alu_reg_reset");

    // R8 = 3, ALU-immediate with negative immediate
    write_reg(4'd8, 32'd3);
    instruction = 32'h6280FFFF;
    expect_out(mk(32'd3, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 4'd2, 2'b01, 2'b10, 6'b100000));
    compare_out("alu_imm_neg");

    // R1 = 0x100, memory write
    write_reg(4'd1, 32'h100);
    instruction = 32'h98100004;
    expect_out(mk(32'h100, 32'd4, 32'd3, 32'h0, 32'h0, 4'd8, 2'b10, 2'b01, 6'b001000));
    compare_out("mem_write");

    // Branch with negative 24-bit offset
    PCi = 32'h0C;
    instruction = 32'hC0FFFFF0;
    expect_out(mk(32'h0C, 32'hFFFFFFF0, 32'h0, 32'h0C, 32'h0, 4'd0, 2'b11, 2'b00, 6'b000001));
    compare_out("branch_neg");

    // Same-cycle bypass on RM, then the value persists once written
    PCi = 32'h0;
    instruction = 32'h21130000;
    WE = 1'b1; RDwb = 4'd3; WBd = 32'd7;
    expect_out(mk(32'h100, 32'd7, 32'h100, 32'h0, 32'd7, 4'd1, 2'b00, 2'b10, 6'b100000));
    compare_out("bypass_pre_edge");
    tick();
    WE = 1'b0;
    expect_out(mk(32'h100, 32'd7, 32'h100, 32'h0, 32'd7, 4'd1, 2'b00, 2'b10, 6'b100000));
    compare_out("bypass_post_edge");

    // Reset beats write enable; bypass still visible during reset
    rst = 1'b1; WE = 1'b1; RDwb = 4'd8; WBd = 32'd9;
    instruction = 32'h6280FFFF;
    expect_out(mk(32'd9, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 4'd2, 2'b01, 2'b10, 6'b100000));
    compare_out("bypass_in_reset");
    tick();
    rst = 1'b0; WE = 1'b0;
    expect_out(mk(32'h0, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 4'd2, 2'b01, 2'b10, 6'b100000));
    compare_out("reset_over_we_r8");
    instruction = 32'h21130000;
    expect_out(mk(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 4'd1, 2'b00, 2'b10, 6'b100000));
    compare_out("reset_cleared_r1_r3");

    // R0 is an ordinary register
    write_reg(4'd0, 32'hDEADBEEF);
    instruction = 32'h00000000;
    expect_out(mk(32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF,
                  4'd0, 2'b00, 2'b00, 6'b100000));
    compare_out("r0_not_hardwired");

    // Sweep all FUNTYPE x FUNCODE with RD=5, RN=6, RM=7, IMM16=0x8001
    write_reg(4'd5, 32'h55);
    write_reg(4'd6, 32'h66);
    write_reg(4'd7, 32'h77);
    PCi = 32'h1234;
    for (int ft = 0; ft < 4; ft++) begin
      for (int fc = 0; fc < 4; fc++) begin
        instr = {ft[1:0], fc[1:0], 4'h5, 4'h6, 4'h7, 16'h8001};
        instruction = instr;
        if (ft == 3) begin
          opa_e = 32'h1234;
          opb_e = 32'h00678001;
        end else if (ft == 0) begin
          opa_e = 32'h66;
          opb_e = 32'h77;
        end else begin
          opa_e = 32'h66;
          opb_e = 32'hFFFF8001;
        end
        expect_out(mk(opa_e, opb_e, 32'h55, 32'h1234, 32'h77, 4'd5,
                      ft[1:0], fc[1:0], strobe_ref(ft[1:0], fc[1:0])));
        compare_out($sformatf("sweep_ft%0d_fc%0d", ft, fc));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
